// File: rtl/lb_pkg.sv
// Shared types and default sizing for the layer ping-pong local buffers.
package lb_pkg;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } lb_bank_e;

    // Generic defaults, matching the old fixed 912x128 layer wrappers
    localparam int LB_DATA_W = 128;
    localparam int LB_DEPTH  = 912;

    // Per-layer instance sizes
    localparam int LB_L1_DATA_W = 128;
    localparam int LB_L1_DEPTH  = 912;
    localparam int LB_L2_DATA_W = 128;
    localparam int LB_L2_DEPTH  = 912;
    localparam int LB_L3_DATA_W = 128;
    localparam int LB_L3_DEPTH  = 912;

endpackage

// File: rtl/lb_bank_ram.sv
// One bank: behavioural 1R1W synchronous RAM with a registered read port.
// The storage array is not reset; only the read register is cleared.
module lb_bank_ram #(
    parameter int W      = 128,
    parameter int DEPTH  = 912,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      q
);

    logic [W-1:0] mem [DEPTH];

    // Write port; the caller only asserts we for in-range addresses
    always_ff @(posedge CK) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register holds its value when no read is issued
    always_ff @(posedge CK or posedge RST) begin
        if (RST)     q <= '0;
        else if (re) q <= mem[raddr];
    end

endmodule

// File: rtl/layer_pingpong_buffer.sv
// Two-bank ping-pong buffer between a producing and a consuming layer engine.
// The producer fills wr_bank while the consumer drains rd_bank; ownership
// moves through wr_done (commit) and rd_done (release).
// Optional: define LB_PARITY_EN to store an even-parity bit per word and
// expose rd_perr on reads.
module layer_pingpong_buffer
    import lb_pkg::*;
#(
    parameter int DATA_W = LB_DATA_W,
    parameter int DEPTH  = LB_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_done,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [LEN_W-1:0]  rd_len,
`ifdef LB_PARITY_EN
    output logic              rd_perr,
`endif
    output logic [1:0]        bank_full
);

`ifdef LB_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam int STAGES = 1;
    localparam logic [ADDR_W:0]  DEPTH_X = DEPTH[ADDR_W:0];
    localparam logic [LEN_W-1:0] DEPTH_L = DEPTH[LEN_W-1:0];

    lb_bank_e                  wr_bank, rd_bank, rd_sel;
    logic [1:0]                full;
    logic [1:0][LEN_W-1:0]     len;
    logic [1:0][MEM_W-1:0]     q;
    logic [MEM_W-1:0]          wdata_m;
    logic [STAGES:0]           vld_pipe;
    logic                      wr_acc, rd_acc, rd_inr, commit, release_b, rd_oor;
    logic                      wr_nb;

    assign wr_ready  = !full[wr_bank];
    assign rd_ready  = full[rd_bank];
    assign wr_acc    = wr_en & wr_ready & ({1'b0, wr_addr} < DEPTH_X);
    assign commit    = wr_done & wr_ready;
    assign rd_acc    = rd_en & rd_ready;
    assign rd_inr    = {1'b0, rd_addr} < DEPTH_X;
    assign release_b = rd_done & rd_ready;
    assign wr_nb     = ~wr_bank;
    assign bank_full = full;
    assign rd_len    = len[rd_bank];

`ifdef LB_PARITY_EN
    assign wdata_m = {^wr_data, wr_data};
`else
    assign wdata_m = wr_data;
`endif

    // Bank array; ports steered by the ownership pointers
    for (genvar b = 0; b < 2; b++) begin : g_bank
        lb_bank_ram #(.W(MEM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
            .CK    (CK),
            .RST   (RST),
            .we    (wr_acc && (wr_bank == lb_bank_e'(b))),
            .waddr (wr_addr),
            .wdata (wdata_m),
            .re    (rd_acc && rd_inr && (rd_bank == lb_bank_e'(b))),
            .raddr (rd_addr),
            .q     (q[b])
        );
    end

    // Ownership flags, pointers and per-bank fill counts. A released bank is
    // empty and not being written, so its count is cleared there too; this
    // keeps a bank that was full at commit time from carrying a stale count
    // into its next fill.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            full    <= '0;
            wr_bank <= BANK0;
            rd_bank <= BANK0;
            len     <= '0;
        end else begin
            if (wr_acc && (len[wr_bank] < DEPTH_L))
                len[wr_bank] <= len[wr_bank] + LEN_W'(1);
            if (commit) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= lb_bank_e'(wr_nb);
                if (!full[wr_nb]) len[wr_nb] <= '0;
            end
            if (release_b) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= lb_bank_e'(~rd_bank);
                len[rd_bank]  <= '0;
            end
        end
    end

    // Read pipeline: remember which bank and whether the address was in range
    assign vld_pipe[0] = rd_acc;
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            vld_pipe[STAGES:1] <= '0;
            rd_sel             <= BANK0;
            rd_oor             <= 1'b0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (rd_acc) begin
                rd_sel <= rd_bank;
                rd_oor <= !rd_inr;
            end
        end
    end

    assign rd_valid = vld_pipe[STAGES];
    assign rd_data  = rd_oor ? '0 : q[rd_sel][DATA_W-1:0];
`ifdef LB_PARITY_EN
    assign rd_perr  = vld_pipe[STAGES] & !rd_oor & (^q[rd_sel]);
`endif

endmodule
